// File: rtl/spi_master_ctrl_pkg.sv
// Shared register map, bit positions and FSM state encoding for the SPI master controller.
package spi_ctrl_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_DIV    = 8'h01;
  localparam logic [7:0] ADDR_TXDATA = 8'h02;
  localparam logic [7:0] ADDR_RXDATA = 8'h03;
  localparam logic [7:0] ADDR_STATUS = 8'h04;

  localparam int CTRL_START   = 0;
  localparam int CTRL_MODE    = 1;
  localparam int CTRL_CS_HOLD = 2;

  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_e;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Register port plus SPI pins of the master controller.
// master = controller side, slave = register host / SPI target side.
interface spi_master_ctrl_if;
  logic [7:0] reg_addr;
  logic       reg_write;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       ready;
  logic       cs_n;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       mode;

  modport master (
    input  reg_addr, reg_write, reg_wdata, miso,
    output reg_rdata, ready, cs_n, sclk, mosi, mode
  );

  modport slave (
    output reg_addr, reg_write, reg_wdata, miso,
    input  reg_rdata, ready, cs_n, sclk, mosi, mode
  );
endinterface

// File: rtl/spi_master_ctrl_clk_div.sv
// Half-period timer: emits a one-cycle tick every DIV+1 cycles, restarted by load_i.
// Tick is combinational from the counter register; no backpressure.
module spi_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;

  assign tick_o = (cnt_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load_i || tick_o) begin
      cnt_q <= div_i;
    end else begin
      cnt_q <= cnt_q - DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Register-programmed SPI master: one DATA_W-bit full-duplex transfer per START, MSB first.
// Start write at t reaches DONE at t+1+(2*DATA_W+2)*(DIV+1); config writes ignored while busy (ready=0).
module spi_master_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int DIV_W  = 8,
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  spi_master_ctrl_if.master  bus
);

  localparam int HP_W = $clog2(2 * DATA_W);
  localparam logic [HP_W-1:0] LAST_HP = HP_W'(2 * DATA_W - 1);

  state_e            state_q;
  logic [DIV_W-1:0]  div_q;
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] tx_sh_q;
  logic [DATA_W-1:0] rx_sh_q;
  logic [DATA_W-1:0] rx_q;
  logic [HP_W-1:0]   hp_q;
  logic              mode_q;
  logic              cs_hold_q;
  logic              cs_n_q;
  logic              sclk_q;
  logic              done_q;
  logic [7:0]        rdata_q;

  logic              idle;
  logic              wr_ctrl;
  logic              wr_div;
  logic              wr_tx;
  logic              w1c;
  logic              start;
  logic              tick;
  logic [HP_W-1:0]   hp_d;
  logic              sclk_d;
  logic              rise;
  logic              fall;
  logic              done_d;
  logic [7:0]        rdata_d;

  assign idle    = (state_q == IDLE);
  assign wr_ctrl = bus.reg_write && (bus.reg_addr == ADDR_CTRL) && idle;
  assign wr_div  = bus.reg_write && (bus.reg_addr == ADDR_DIV) && idle;
  assign wr_tx   = bus.reg_write && (bus.reg_addr == ADDR_TXDATA) && idle;
  assign w1c     = bus.reg_write && (bus.reg_addr == ADDR_STATUS) && bus.reg_wdata[STATUS_DONE];
  assign start   = wr_ctrl && bus.reg_wdata[CTRL_START];

  // Even half-periods sit at the non-idle level, so mode 0 opens with a rise and mode 3 with a fall.
  assign hp_d   = (state_q == SHIFT) ? hp_q + HP_W'(1) : '0;
  assign sclk_d = mode_q ? hp_d[0] : ~hp_d[0];
  assign rise   = sclk_d & ~sclk_q;
  assign fall   = ~sclk_d & sclk_q;

  spi_clk_div #(.DIV_W(DIV_W)) u_clk_div (
    .clk    (clk),
    .reset_n(reset_n),
    .load_i (start),
    .div_i  (div_q),
    .tick_o (tick)
  );

  always_comb begin
    done_d = done_q;
    if (w1c) begin
      done_d = 1'b0;
    end
    if (state_q == DONE) begin
      done_d = 1'b1;
    end
  end

  always_comb begin
    rdata_d = '0;
    case (bus.reg_addr)
      ADDR_CTRL: begin
        rdata_d[CTRL_MODE]    = mode_q;
        rdata_d[CTRL_CS_HOLD] = cs_hold_q;
      end
      ADDR_DIV:    rdata_d = 8'(div_q);
      ADDR_TXDATA: rdata_d = 8'(tx_q);
      ADDR_RXDATA: rdata_d = 8'(rx_q);
      ADDR_STATUS: begin
        rdata_d[STATUS_BUSY] = ~idle;
        rdata_d[STATUS_DONE] = done_q;
      end
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      tx_q      <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_q      <= '0;
      hp_q      <= '0;
      mode_q    <= 1'b0;
      cs_hold_q <= 1'b0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rdata_q <= rdata_d;
      done_q  <= done_d;
      if (wr_div) begin
        div_q <= DIV_W'(bus.reg_wdata);
      end
      if (wr_tx) begin
        tx_q <= DATA_W'(bus.reg_wdata);
      end
      case (state_q)
        IDLE: begin
          if (wr_ctrl) begin
            mode_q    <= bus.reg_wdata[CTRL_MODE];
            cs_hold_q <= bus.reg_wdata[CTRL_CS_HOLD];
            sclk_q    <= bus.reg_wdata[CTRL_MODE];
            if (start) begin
              state_q <= SETUP;
              cs_n_q  <= 1'b0;
              tx_sh_q <= tx_q;
              rx_sh_q <= '0;
            end else begin
              cs_n_q <= cs_n_q | ~bus.reg_wdata[CTRL_CS_HOLD];
            end
          end
        end
        SETUP, SHIFT: begin
          if (tick) begin
            if ((state_q == SHIFT) && (hp_q == LAST_HP)) begin
              state_q <= HOLD;
            end else begin
              state_q <= SHIFT;
              hp_q    <= hp_d;
              sclk_q  <= sclk_d;
              if (rise) begin
                rx_sh_q <= {rx_sh_q[DATA_W-2:0], bus.miso};
              end
              // No shift before the first sample (mode 3 lead-in) nor after the last one (mode 0 tail).
              if (fall && (hp_d != '0) && (hp_d != LAST_HP)) begin
                tx_sh_q <= tx_sh_q << 1;
              end
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state_q <= DONE;
            cs_n_q  <= ~cs_hold_q;
          end
        end
        DONE: begin
          rx_q    <= rx_sh_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.reg_rdata = rdata_q;
  assign bus.ready     = idle;
  assign bus.cs_n      = cs_n_q;
  assign bus.sclk      = sclk_q;
  assign bus.mosi      = tx_sh_q[DATA_W-1];
  assign bus.mode      = mode_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboarded bench for spi_master_ctrl: driver queues expected transfers/reads,
// an SPI-pin monitor plays the slave and a read monitor checks registered readback.
module tb_spi_master_ctrl;

  localparam logic [7:0] A_CTRL = 8'h00;
  localparam logic [7:0] A_DIV  = 8'h01;
  localparam logic [7:0] A_TX   = 8'h02;
  localparam logic [7:0] A_RX   = 8'h03;
  localparam logic [7:0] A_STAT = 8'h04;

  typedef struct {
    logic [7:0] tx;
    int         div;
    bit         mode;
    bit         cs_hold;
  } xfer_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  spi_master_ctrl_if bus ();

  spi_master_ctrl #(.DIV_W(8), .DATA_W(8)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;

  xfer_t      xfer_q[$];
  logic [7:0] slave_q[$];
  logic [7:0] rd_q[$];
  string      rd_name_q[$];
  logic       rd_vld = 1'b0;
  logic       rd_vld_d = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got nothing expected an event", name);
  endtask

  // Read monitor: reg_rdata one cycle after the address was presented.
  always @(posedge clk) rd_vld_d <= rd_vld;

  always @(negedge clk) begin
    if (rd_vld_d) begin
      if (rd_q.size() == 0) begin
        fail_now("read_scoreboard_empty");
      end else begin
        chk(rd_name_q.pop_front(), 32'(bus.reg_rdata), 32'(rd_q.pop_front()));
      end
    end
  end

  // SPI monitor and slave: counts sclk rises during a transfer, drives miso MSB first.
  int         cyc = 0;
  bit         in_xfer = 1'b0;
  bit         prev_ready = 1'b1;
  bit         prev_sclk = 1'b0;
  int         start_cyc, rises, first_rise, spacing;
  logic [7:0] mosi_byte, slave_cur;
  xfer_t      e;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      in_xfer = 1'b0;
      prev_ready = 1'b1;
      prev_sclk = 1'b0;
      bus.miso = 1'b0;
    end else begin
      if (!in_xfer && prev_ready && !bus.ready) begin
        in_xfer = 1'b1;
        start_cyc = cyc;
        rises = 0;
        spacing = -1;
        mosi_byte = '0;
        if (slave_q.size() == 0) begin
          fail_now("slave_queue_empty");
          slave_cur = '0;
        end else begin
          slave_cur = slave_q.pop_front();
        end
        bus.miso = slave_cur[7];
      end else if (in_xfer && !prev_sclk && bus.sclk) begin
        if (rises == 0) first_rise = cyc;
        else if (rises == 1) spacing = cyc - first_rise;
        mosi_byte = {mosi_byte[6:0], bus.mosi};
        rises++;
        bus.miso = (rises < 8) ? slave_cur[3'(7 - rises)] : 1'b0;
      end
      if (in_xfer && bus.ready) begin
        in_xfer = 1'b0;
        if (xfer_q.size() == 0) begin
          fail_now("xfer_scoreboard_empty");
        end else begin
          e = xfer_q.pop_front();
          chk("xfer_mosi_byte", 32'(mosi_byte), 32'(e.tx));
          chk("xfer_rise_count", rises, 8);
          chk("xfer_busy_cycles", cyc - start_cyc, (2 * 8 + 2) * (e.div + 1) + 1);
          chk("xfer_rise_spacing", spacing, 2 * (e.div + 1));
          chk("xfer_sclk_idle", 32'(bus.sclk), 32'(e.mode));
          chk("xfer_cs_n_after", 32'(bus.cs_n), 32'(!e.cs_hold));
        end
      end
    end
    prev_ready = bus.ready;
    prev_sclk = bus.sclk;
  end

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.reg_addr = a;
    bus.reg_wdata = d;
    bus.reg_write = 1'b1;
    @(negedge clk);
    bus.reg_write = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
    @(negedge clk);
    bus.reg_addr = a;
    rd_q.push_back(exp);
    rd_name_q.push_back(name);
    rd_vld = 1'b1;
    @(negedge clk);
    rd_vld = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] tx, input int div, input bit mode, input bit hold,
                      input logic [7:0] slv, input bit expect_done);
    xfer_t x;
    x.tx = tx;
    x.div = div;
    x.mode = mode;
    x.cs_hold = hold;
    wr(A_DIV, 8'(div));
    wr(A_TX, tx);
    slave_q.push_back(slv);
    if (expect_done) xfer_q.push_back(x);
    wr(A_CTRL, {5'b0, hold, mode, 1'b1});
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (bus.ready !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (bus.ready !== 1'b1) fail_now("wait_idle_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tx, slv, a;
    int         div;
    bit         mode, hold;

    bus.reg_addr = '0;
    bus.reg_wdata = '0;
    bus.reg_write = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_cs_n", 32'(bus.cs_n), 1);
    chk("reset_sclk", 32'(bus.sclk), 0);
    chk("reset_mosi", 32'(bus.mosi), 0);
    chk("reset_mode", 32'(bus.mode), 0);
    chk("reset_ready", 32'(bus.ready), 1);
    chk("reset_rdata", 32'(bus.reg_rdata), 0);
    reset_n = 1'b1;
    rd(A_STAT, 8'h00, "status_after_reset");
    rd(A_DIV, 8'h00, "div_after_reset");

    // Mode 0, fastest divider.
    xfer(8'hA5, 0, 1'b0, 1'b0, 8'h3C, 1'b1);
    wait_idle(500);
    rd(A_RX, 8'h3C, "t1_rxdata");
    rd(A_STAT, 8'h02, "t1_status_done");

    // Mode 3, divider 3.
    xfer(8'h81, 3, 1'b1, 1'b0, 8'h5A, 1'b1);
    wait_idle(500);
    rd(A_RX, 8'h5A, "t2_rxdata");
    rd(A_CTRL, 8'h02, "t2_ctrl_mode");

    // Config writes while busy must be dropped.
    xfer(8'hC3, 2, 1'b0, 1'b0, 8'h96, 1'b1);
    wr(A_TX, 8'hFF);
    wr(A_DIV, 8'h05);
    rd(A_STAT, 8'h03, "t3_status_busy");
    wait_idle(500);
    rd(A_TX, 8'hC3, "t3_txdata_kept");
    rd(A_DIV, 8'h02, "t3_div_kept");
    rd(A_RX, 8'h96, "t3_rxdata");

    // Chip select held across back-to-back transfers.
    xfer(8'h12, 0, 1'b0, 1'b1, 8'hE7, 1'b1);
    wait_idle(500);
    @(negedge clk);
    chk("t4_cs_n_gap", 32'(bus.cs_n), 0);
    xfer(8'h34, 0, 1'b0, 1'b1, 8'h18, 1'b1);
    wait_idle(500);
    rd(A_RX, 8'h18, "t4_rxdata");
    chk("t4_cs_n_still_low", 32'(bus.cs_n), 0);
    wr(A_CTRL, 8'h00);
    chk("t4_cs_n_release", 32'(bus.cs_n), 1);

    // Asynchronous reset in the middle of the shift.
    xfer(8'hB4, 0, 1'b0, 1'b0, 8'h6D, 1'b0);
    repeat (7) @(negedge clk);
    chk("t5_busy_before_reset", 32'(bus.ready), 0);
    reset_n = 1'b0;
    #1;
    chk("t5_async_cs_n", 32'(bus.cs_n), 1);
    chk("t5_async_sclk", 32'(bus.sclk), 0);
    chk("t5_async_ready", 32'(bus.ready), 1);
    chk("t5_async_rdata", 32'(bus.reg_rdata), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd(A_RX, 8'h00, "t5_rxdata_cleared");
    rd(A_TX, 8'h00, "t5_txdata_cleared");
    rd(A_STAT, 8'h00, "t5_status_cleared");
    xfer(8'h4B, 1, 1'b1, 1'b0, 8'hD2, 1'b1);
    wait_idle(500);
    rd(A_RX, 8'hD2, "t5_rxdata_after");

    // DONE set beats a simultaneous W1C; later W1C clears.
    wr(A_STAT, 8'h02);
    rd(A_STAT, 8'h00, "t6_done_cleared_pre");
    xfer(8'h5C, 0, 1'b0, 1'b0, 8'h33, 1'b1);
    repeat ((2 * 8 + 2) * 1 - 1) @(negedge clk);
    wr(A_STAT, 8'h02);
    rd(A_STAT, 8'h02, "t6_done_set_wins");
    wr(A_STAT, 8'h02);
    rd(A_STAT, 8'h00, "t6_done_w1c");
    wr(8'h07, 8'hFF);
    rd(8'h07, 8'h00, "t6_unmapped_read");

    // Randomised transfers.
    for (int i = 0; i < 10; i++) begin
      tx = 8'($urandom);
      slv = 8'($urandom);
      div = int'($urandom_range(0, 3));
      mode = 1'($urandom_range(0, 1));
      hold = 1'($urandom_range(0, 1));
      xfer(tx, div, mode, hold, slv, 1'b1);
      wait_idle(500);
      rd(A_RX, slv, "rand_rxdata");
      rd(A_CTRL, {5'b0, hold, mode, 1'b0}, "rand_ctrl");
      rd(A_STAT, 8'h02, "rand_status");
      a = 8'($urandom_range(5, 255));
      wr(a, 8'($urandom));
      rd(a, 8'h00, "rand_unmapped");
    end

    repeat (3) @(negedge clk);
    chk("xfer_scoreboard_drained", xfer_q.size(), 0);
    chk("read_scoreboard_drained", rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
